// File: rtl/fpu_sqrt_if.sv
// rtl/fpu_sqrt_if.sv - start/busy/cmd_end request interface for the sqrt unit
interface fpu_sqrt_if #(
    parameter int W = 32
);
    logic         start;
    logic [W-1:0] operand;
    logic [W-1:0] result;
    logic         busy;
    logic         cmd_end;
    logic         invalid;
    logic         inexact;

    modport master (
        output start, operand,
        input  result, busy, cmd_end, invalid, inexact
    );

    modport slave (
        input  start, operand,
        output result, busy, cmd_end, invalid, inexact
    );
endinterface

// File: rtl/fpu_sqrt_unit.sv
// rtl/fpu_sqrt_unit.sv - multi-cycle IEEE-754 square root; FPU_SQRT_RNE_EN selects round-to-nearest-even
module fpu_sqrt_unit #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic        clk,
    input  logic        arst_n,
    fpu_sqrt_if.slave   bus
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int N    = MAN_W + 2;
    localparam int RW   = N + 2;
    localparam int RADW = 2 * N;
    localparam int EW   = EXP_W + 2;
    localparam int CW   = $clog2(N + 1);

    localparam logic [EXP_W-1:0] BIAS = {1'b0, {(EXP_W-1){1'b1}}};
    localparam logic [W-1:0]     QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0]     PINF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, ITER, ROUND, DONE} state_t;

    state_t            state;
    logic [W-1:0]      op_q;
    logic [RADW-1:0]   rad;
    logic [RW-1:0]     rem;
    logic [N-1:0]      root;
    logic [CW-1:0]     cnt;
    logic [EXP_W-1:0]  rexp;
    logic [W-1:0]      result_q;
    logic              busy_q, cmd_end_q, invalid_q, inexact_q;

    assign bus.result  = result_q;
    assign bus.busy    = busy_q;
    assign bus.cmd_end = cmd_end_q;
    assign bus.invalid = invalid_q;
    assign bus.inexact = inexact_q;

    logic             op_sign;
    logic [EXP_W-1:0] op_exp;
    logic [MAN_W-1:0] op_man;
    assign op_sign = op_q[W-1];
    assign op_exp  = op_q[W-2:MAN_W];
    assign op_man  = op_q[MAN_W-1:0];

    logic         special, special_inv;
    logic [W-1:0] special_res;

    // Subnormals are flushed before the sign test, so a negative subnormal yields -0.
    always_comb begin
        special     = 1'b1;
        special_inv = 1'b0;
        special_res = QNAN;
        if ((&op_exp) && (op_man != '0)) begin
            special_res = QNAN;
        end else if (op_exp == '0) begin
            special_res = {op_sign, {(W-1){1'b0}}};
        end else if (op_sign) begin
            special_inv = 1'b1;
        end else if (&op_exp) begin
            special_res = PINF;
        end else begin
            special = 1'b0;
        end
    end

    logic signed [EW-1:0] e_unb, e_adj, e_half;
    logic [RADW-1:0]      sig_ext, rad_init;
    assign e_unb    = $signed({2'b00, op_exp}) - $signed({2'b00, BIAS});
    assign e_adj    = e_unb - EW'(e_unb[0]);
    assign e_half   = e_adj >>> 1;
    assign sig_ext  = {{(RADW-MAN_W-1){1'b0}}, 1'b1, op_man};
    // Root integer bit lands in root[N-1]; odd exponents fold one factor of 2 into the radicand.
    assign rad_init = e_unb[0] ? (sig_ext << (MAN_W + 3)) : (sig_ext << (MAN_W + 2));

    logic [RW-1:0] rem_sh, trial, rem_nx;
    logic          take;
    assign rem_sh = {rem[RW-3:0], rad[RADW-1:RADW-2]};
    assign trial  = {root, 2'b01};
    assign take   = (rem_sh >= trial);
    assign rem_nx = take ? (rem_sh - trial) : rem_sh;

    logic             guard, sticky, inc;
    logic [MAN_W:0]   mant_sum;
    logic [EXP_W-1:0] exp_out;
    assign guard  = root[0];
    assign sticky = |rem;
`ifdef FPU_SQRT_RNE_EN
    assign inc = guard & (sticky | root[1]);
`else
    assign inc = 1'b0;
`endif
    assign mant_sum = {1'b0, root[N-2:1]} + (MAN_W+1)'(inc);
    assign exp_out  = rexp + EXP_W'(mant_sum[MAN_W]);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            rad       <= '0;
            rem       <= '0;
            root      <= '0;
            cnt       <= '0;
            rexp      <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            cmd_end_q <= 1'b0;
            invalid_q <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.operand;
                        busy_q <= 1'b1;
                        state  <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (special) begin
                        result_q  <= special_res;
                        invalid_q <= special_inv;
                        inexact_q <= 1'b0;
                        busy_q    <= 1'b0;
                        cmd_end_q <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rad   <= rad_init;
                        rem   <= '0;
                        root  <= '0;
                        cnt   <= CW'(N);
                        rexp  <= EXP_W'(e_half + $signed(EW'(BIAS)));
                        state <= ITER;
                    end
                end
                ITER: begin
                    rem  <= rem_nx;
                    root <= {root[N-2:0], take};
                    rad  <= {rad[RADW-3:0], 2'b00};
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= ROUND;
                end
                ROUND: begin
                    // A mantissa carry-out leaves mant_sum low bits zero, so only the exponent needs bumping.
                    result_q  <= {1'b0, exp_out, mant_sum[MAN_W-1:0]};
                    invalid_q <= 1'b0;
                    inexact_q <= guard | sticky;
                    busy_q    <= 1'b0;
                    cmd_end_q <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    cmd_end_q <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_sqrt_unit.sv
// tb/tb_fpu_sqrt_unit.sv - scoreboard bench for fpu_sqrt_unit
module tb_fpu_sqrt_unit;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 32;
    localparam int LAT_N = MAN_W + 4;
    localparam int LAT_S = 1;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_sqrt_if #(.W(W)) bus ();

    fpu_sqrt_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] res;
        logic        inv;
        logic        inx;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int pulses = 0;
    int n_ops = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] x, output logic inx);
        logic [63:0] db, rb;
        logic [51:0] dm;
        logic [22:0] m;
        logic [7:0]  e;
        logic        g, s;
        logic [23:0] sum;
        db  = {1'b0, 11'(x[30:23]) - 11'd127 + 11'd1023, x[22:0], 29'd0};
        rb  = $realtobits($sqrt($bitstoreal(db)));
        dm  = rb[51:0];
        m   = dm[51:29];
        g   = dm[28];
        s   = |dm[27:0];
        e   = 8'(rb[62:52] - 11'd1023 + 11'd127);
        inx = g | s;
`ifdef FPU_SQRT_RNE_EN
        sum = {1'b0, m} + 24'(g & (s | m[0]));
`else
        sum = {1'b0, m};
`endif
        if (sum[23]) e = e + 8'd1;
        return {1'b0, e, sum[22:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.busy) busy_cnt++;
        if (bus.cmd_end) begin
            pulses++;
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon = sb.pop_front();
                check("result",  bus.result,  mon.res);
                check("invalid", bus.invalid, mon.inv);
                check("inexact", bus.inexact, mon.inx);
                check("latency", 64'(cyc - mon.acc), 64'(mon.lat));
                check("busy_cycles", 64'(busy_cnt), 64'(mon.lat));
            end
        end
    end

    task automatic run_op(input logic [31:0] op, input logic [31:0] res,
                          input logic inv, input logic inx, input int lat, input bit poke);
        exp_t it;
        int n0;
        n0 = pulses;
        n_ops++;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.operand = op;
        busy_cnt    = 0;
        @(posedge clk);
        #1;
        it.res = res; it.inv = inv; it.inx = inx; it.lat = lat; it.acc = cyc;
        sb.push_back(it);
        bus.start = 1'b0;
        if (poke) begin
            repeat (3) @(negedge clk);
            bus.operand = 32'h4080_0000;
            bus.start   = 1'b1;
            @(negedge clk);
            bus.start   = 1'b0;
        end
        for (int i = 0; i < 100 && pulses == n0; i++) begin
            @(negedge clk);
            #1;
        end
        check("done_seen", 64'(pulses > n0), 64'd1);
        repeat (2) @(negedge clk);
        check("result_hold", bus.result, res);
    endtask

    logic [31:0] rop, rres;
    logic        rinx;
    int          n0;

    initial begin
        bus.start   = 1'b0;
        bus.operand = '0;
        #12;
        check("rst_result",  bus.result,  0);
        check("rst_busy",    bus.busy,    0);
        check("rst_cmd_end", bus.cmd_end, 0);
        check("rst_invalid", bus.invalid, 0);
        check("rst_inexact", bus.inexact, 0);
        @(negedge clk);
        arst_n = 1'b1;

        run_op(32'h4180_0000, 32'h4080_0000, 1'b0, 1'b0, LAT_N, 1'b0);
`ifdef FPU_SQRT_RNE_EN
        run_op(32'h40A0_0000, 32'h400F_1BBD, 1'b0, 1'b1, LAT_N, 1'b0);
`else
        run_op(32'h40A0_0000, 32'h400F_1BBC, 1'b0, 1'b1, LAT_N, 1'b0);
`endif
        run_op(32'hC080_0000, 32'h7FC0_0000, 1'b1, 1'b0, LAT_S, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, LAT_S, 1'b0);
        run_op(32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b0, LAT_S, 1'b0);
        run_op(32'hFF80_0000, 32'h7FC0_0000, 1'b1, 1'b0, LAT_S, 1'b0);
        run_op(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, LAT_S, 1'b0);
        run_op(32'h7FA0_0000, 32'h7FC0_0000, 1'b0, 1'b0, LAT_S, 1'b0);
        run_op(32'h0080_0000, 32'h2000_0000, 1'b0, 1'b0, LAT_N, 1'b0);
        run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, LAT_N, 1'b0);
        run_op(32'h4000_0000, 32'h3FB5_04F3, 1'b0, 1'b1, LAT_N, 1'b1);

        rres = model(32'h7F7F_FFFF, rinx);
        run_op(32'h7F7F_FFFF, rres, 1'b0, rinx, LAT_N, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rop  = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            rres = model(rop, rinx);
            run_op(rop, rres, 1'b0, rinx, LAT_N, 1'b0);
        end

        n0 = pulses;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.operand = 32'h4110_0000;
        @(negedge clk);
        bus.start   = 1'b0;
        repeat (9) @(negedge clk);
        arst_n = 1'b0;
        #1;
        check("arst_result",  bus.result,  0);
        check("arst_busy",    bus.busy,    0);
        check("arst_cmd_end", bus.cmd_end, 0);
        check("arst_invalid", bus.invalid, 0);
        check("arst_inexact", bus.inexact, 0);
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("no_cmd_end_after_abort", 64'(pulses), 64'(n0));
        run_op(32'h4110_0000, 32'h4040_0000, 1'b0, 1'b0, LAT_N, 1'b0);

        repeat (40) @(negedge clk);
        check("pulse_count", 64'(pulses), 64'(n_ops));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
